// File: rtl/t_flip_flop_pkg.sv
// Shared constants for the toggle flip-flop bank.
package t_flip_flop_pkg;

  // Classic single T flip-flop unless the instantiator asks for a bank.
  localparam int unsigned TFF_DEFAULT_WIDTH = 1;

endpackage : t_flip_flop_pkg

// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent T flip-flops with synchronous active-high reset.
// Q is taken straight from the state register; T and rst only act at clk rise.
module t_flip_flop
  import t_flip_flop_pkg::*;
#(
  parameter int unsigned           WIDTH       = TFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state: each bit inverts where its toggle request is set; no carries.
  always_comb begin
    q_d = q_q ^ T;
  end

  // State register; reset wins over any toggle request on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule : t_flip_flop

// File: tb/tb_t_flip_flop.sv
// Randomized and directed bench for t_flip_flop (1-bit and 4-bit instances).
// Reference model: Q[i] = RESET_VALUE[i] XOR parity(toggle requests since last reset).
module tb_t_flip_flop;

  localparam logic [3:0] RV4 = 4'b1010;

  logic       clk;
  logic       rst;
  logic       t1;
  logic       q1;
  logic [3:0] t4;
  logic [3:0] q4;

  int unsigned n_tests;
  int unsigned n_fail;

  // Model state: toggle requests seen per bit since the most recent reset edge.
  int unsigned flips1;
  int unsigned flips4 [4];

  t_flip_flop dut1 (
    .clk (clk),
    .rst (rst),
    .T   (t1),
    .Q   (q1)
  );

  t_flip_flop #(
    .WIDTH       (4),
    .RESET_VALUE (RV4)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .T   (t4),
    .Q   (q4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_q1();
    return flips1[0];
  endfunction

  function automatic logic [3:0] exp_q4();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = RV4[i] ^ flips4[i][0];
    return e;
  endfunction

  // Advance the model with the inputs present at the coming edge, then check after it.
  task automatic tick(input string tag);
    if (rst) begin
      flips1 = 0;
      for (int i = 0; i < 4; i++) flips4[i] = 0;
    end else begin
      flips1 += int'(t1);
      for (int i = 0; i < 4; i++) flips4[i] += int'(t4[i]);
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_q1"}, 32'(q1), 32'(exp_q1()));
    check_eq({tag, "_q4"}, 32'(q4), 32'(exp_q4()));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    flips1  = 0;
    for (int i = 0; i < 4; i++) flips4[i] = 0;
    rst = 1'b1;
    t1  = 1'b1;
    t4  = 4'b1111;

    // Reset beats toggle for several edges.
    for (int k = 0; k < 5; k++) tick("rst_hold");
    check_eq("rst_q1_const", 32'(q1), 32'(1'b0));
    check_eq("rst_q4_const", 32'(q4), 32'(4'b1010));

    // Hold with no toggle requests.
    rst = 1'b0; t1 = 1'b0; t4 = 4'b0000;
    for (int k = 0; k < 5; k++) tick("hold");

    // Single toggle then hold.
    t1 = 1'b1; t4 = 4'b0110;
    tick("single");
    check_eq("single_q4_const", 32'(q4), 32'(4'b1100));
    t1 = 1'b0; t4 = 4'b0000;
    for (int k = 0; k < 3; k++) tick("single_hold");
    check_eq("single_q1_const", 32'(q1), 32'(1'b1));

    // Continuous toggle from Q=0 (restore via reset first).
    rst = 1'b1; tick("pre_cont_rst");
    rst = 1'b0; t1 = 1'b1; t4 = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick("cont");
      check_eq("cont_seq", 32'(q1), 32'((k % 2) == 0));
    end

    // Mid-operation reset with toggle held, then release with toggle.
    tick("mid_pre");
    check_eq("mid_pre_q1", 32'(q1), 32'(1'b1));
    rst = 1'b1;
    tick("mid_rst");
    check_eq("mid_rst_q1", 32'(q1), 32'(1'b0));
    rst = 1'b0;
    tick("mid_release");
    check_eq("mid_release_q1", 32'(q1), 32'(1'b1));

    // Sub-cycle glitch on T between edges has no effect.
    t1 = 1'b0; t4 = 4'b0000;
    #4;
    t1 = 1'b1; t4 = 4'b1111;
    #10;
    t1 = 1'b0; t4 = 4'b0000;
    tick("glitch");
    check_eq("glitch_q1", 32'(q1), 32'(1'b1));

    // Randomized toggles with occasional resets.
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 15) == 0);
      t1  = 1'($urandom);
      t4  = 4'($urandom);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_t_flip_flop
